control_sequencer: RTL and testbench

- Hardwired control unit that drives the DataPath control inputs currently toggled by hand in the instruction benches.
- Runs the fetch cycle (T0–T2), decodes IR, and runs a three-register ALU execute sequence (T3–T5).
- Handshakes with the ALU through start/finished. MUL/DIV results are written to HI/LO instead of the register file.
- Sits directly upstream of DataPath; its outputs connect one-to-one to the same-named DataPath control inputs.

---
 rtl/control_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: fetch (T0-T2), three-register ALU
// execute (T3-T5), and a HI/LO writeback (T6) for MUL/DIV. The outputs are Moore outputs.
module control_sequencer #(
    parameter logic [4:0] MUL_OP  = 5'b01111,
    parameter logic [4:0] DIV_OP  = 5'b10000,
    parameter logic [4:0] HALT_OP = 5'b11011,
    parameter int         TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        finished,
    output logic        PCout,
    output logic        IRout,
    output logic        RYout,
    output logic        RZHIout,
    output logic        MARout,
    output logic        RHIout,
    output logic        RLOout,
    output logic        MDRout,
    output logic        RFout,
    output logic        RZLOout,
    output logic        PCin,
    output logic        IRin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        RHIin,
    output logic        RLOin,
    output logic        MDRin,
    output logic        RFin,
    output logic        IncPC,
    output logic        Read,
    output logic [3:0]  RFSelect,
    output logic [5:0]  opSelect,
    output logic        start,
    output logic        halted,
    output logic        fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T4W, T5, T6, HALTED, FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    logic             hilo_op;
    logic [14:0]      ir_unused;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign ir_unused = IR[14:0];
    assign hilo_op   = (opcode == MUL_OP) || (opcode == DIV_OP);
    assign wait_inc  = wait_cnt + 1'b1;

    always_ff @(posedge Clock) begin
        if (clear) begin
            state    <= RST;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // The wait counter holds the number of cycles elapsed since start; it is
    // zeroed before T4 and faults when it would reach TIMEOUT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RST: state_nxt = T0;
            T0:  state_nxt = T1;
            T1:  state_nxt = T2;
            T2:  state_nxt = (opcode == HALT_OP) ? HALTED : T3;
            T3: begin
                state_nxt    = T4;
                wait_cnt_nxt = '0;
            end
            T4: begin
                if (finished) begin
                    state_nxt = T5;
                end else begin
                    state_nxt    = T4W;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            T4W: begin
                if (finished) begin
                    state_nxt = T5;
                end else if (wait_inc == TIMEOUT_C) begin
                    state_nxt = FAULT;
                end else begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            T5:      state_nxt = hilo_op ? T6 : T0;
            T6:      state_nxt = T0;
            HALTED:  state_nxt = HALTED;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        IRout    = 1'b0;
        RYout    = 1'b0;
        RZHIout  = 1'b0;
        MARout   = 1'b0;
        RHIout   = 1'b0;
        RLOout   = 1'b0;
        MDRout   = 1'b0;
        RFout    = 1'b0;
        RZLOout  = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        MARin    = 1'b0;
        RHIin    = 1'b0;
        RLOin    = 1'b0;
        MDRin    = 1'b0;
        RFin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        RFSelect = 4'd0;
        opSelect = 6'd0;
        start    = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            T1: begin
                RZLOout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                RFSelect = rb;
                RFout    = 1'b1;
                RYin     = 1'b1;
            end
            T4, T4W: begin
                RFSelect = rc;
                RFout    = 1'b1;
                RZin     = 1'b1;
                opSelect = {1'b0, opcode};
                start    = (state == T4);
            end
            T5: begin
                RZLOout = 1'b1;
                if (hilo_op) begin
                    RLOin = 1'b1;
                end else begin
                    RFSelect = ra;
                    RFin     = 1'b1;
                end
            end
            T6: begin
                RZHIout = 1'b1;
                RHIin   = 1'b1;
            end
            HALTED:  halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control vectors are queued per
// cycle and compared 1 time unit after each rising edge.
module tb_control_sequencer;

    localparam int TIMEOUT = 64;
    localparam int S_RST = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5,
                   S_T4W = 6, S_T5 = 7, S_T6 = 8, S_HLT = 9, S_FLT = 10;

    typedef struct packed {
        logic PCout, IRout, RYout, RZHIout, MARout, RHIout, RLOout, MDRout, RFout, RZLOout;
        logic PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin, RFin;
        logic IncPC, Read;
        logic [3:0] RFSelect;
        logic [5:0] opSelect;
        logic start, halted, fault;
    } ctl_t;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        finished;
    logic PCout, IRout, RYout, RZHIout, MARout, RHIout, RLOout, MDRout, RFout, RZLOout;
    logic PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin, RFin, IncPC, Read;
    logic [3:0] RFSelect;
    logic [5:0] opSelect;
    logic start, halted, fault;

    int   tests = 0;
    int   failed = 0;
    ctl_t expq[$];
    ctl_t obs;

    // ALU stand-in: finished rises alu_delay cycles after start, or is held high.
    bit fin_always = 1'b0;
    int alu_delay  = 0;
    int since_start = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (clear)      since_start <= 0;
        else if (start) since_start <= 1;
        else if (since_start > 0) since_start <= since_start + 1;
    end

    assign finished = fin_always | ((alu_delay > 0) && (since_start == alu_delay));

    assign obs = {PCout, IRout, RYout, RZHIout, MARout, RHIout, RLOout, MDRout, RFout, RZLOout,
                  PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin, RFin, IncPC, Read,
                  RFSelect, opSelect, start, halted, fault};

    control_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .finished(finished),
        .PCout(PCout), .IRout(IRout), .RYout(RYout), .RZHIout(RZHIout), .MARout(MARout),
        .RHIout(RHIout), .RLOout(RLOout), .MDRout(MDRout), .RFout(RFout), .RZLOout(RZLOout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .RHIin(RHIin),
        .RLOin(RLOin), .MDRin(MDRin), .RFin(RFin), .IncPC(IncPC), .Read(Read),
        .RFSelect(RFSelect), .opSelect(opSelect), .start(start), .halted(halted), .fault(fault)
    );

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic ctl_t exp_ctl(input int st, input logic [31:0] ir);
        ctl_t       e;
        logic [4:0] op;
        bit         hilo;
        e    = '0;
        op   = ir[31:27];
        hilo = (op == 5'b01111) || (op == 5'b10000);
        case (st)
            S_T0:  begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.RZin = 1; end
            S_T1:  begin e.RZLOout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; end
            S_T2:  begin e.MDRout = 1; e.IRin = 1; end
            S_T3:  begin e.RFSelect = ir[22:19]; e.RFout = 1; e.RYin = 1; end
            S_T4, S_T4W: begin
                e.RFSelect = ir[18:15]; e.RFout = 1; e.RZin = 1;
                e.opSelect = {1'b0, op}; e.start = (st == S_T4);
            end
            S_T5: begin
                e.RZLOout = 1;
                if (hilo) e.RLOin = 1;
                else begin e.RFSelect = ir[26:23]; e.RFin = 1; end
            end
            S_T6:  begin e.RZHIout = 1; e.RHIin = 1; end
            S_HLT: e.halted = 1;
            S_FLT: e.fault = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_instr(input logic [31:0] ir, input int waits);
        logic [4:0] op;
        op = ir[31:27];
        expq.push_back(exp_ctl(S_T0, ir));
        expq.push_back(exp_ctl(S_T1, ir));
        expq.push_back(exp_ctl(S_T2, ir));
        expq.push_back(exp_ctl(S_T3, ir));
        expq.push_back(exp_ctl(S_T4, ir));
        for (int i = 0; i < waits; i++) expq.push_back(exp_ctl(S_T4W, ir));
        expq.push_back(exp_ctl(S_T5, ir));
        if (op == 5'b01111 || op == 5'b10000) expq.push_back(exp_ctl(S_T6, ir));
    endtask

    // Leaves clear low 1 unit after the second clear edge, with the DUT in RST.
    task automatic do_reset();
        clear = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1 clear = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t e;
        IR = mk_ir(5'b11001, 4'd1, 4'd2, 4'd3);
        fin_always = 0; alu_delay = 0;
        #1 clear = 1'b0;
        repeat (4) @(posedge Clock);
        #1 clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            e = exp_ctl(S_RST, IR);
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        clear = 1'b0;
        expq.push_back(exp_ctl(S_T0, IR));
        expq.push_back(exp_ctl(S_T1, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_shr();
        ctl_t e;
        IR = 32'hC8918000;
        fin_always = 0; alu_delay = 3;
        do_reset();
        push_instr(IR, 3);
        expq.push_back(exp_ctl(S_T0, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL shr cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_same_cycle();
        ctl_t e;
        IR = mk_ir(5'b00011, 4'd7, 4'd8, 4'd9);
        fin_always = 1; alu_delay = 0;
        do_reset();
        push_instr(IR, 0);
        expq.push_back(exp_ctl(S_T0, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL same_cycle cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_mul();
        ctl_t e;
        IR = mk_ir(5'b01111, 4'd5, 4'd6, 4'd7);
        fin_always = 1; alu_delay = 0;
        do_reset();
        push_instr(IR, 0);
        expq.push_back(exp_ctl(S_T0, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL mul cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        ctl_t e;
        IR = mk_ir(5'b10000, 4'd10, 4'd11, 4'd12);
        fin_always = 0; alu_delay = 1;
        do_reset();
        push_instr(IR, 1);
        push_instr(IR, 1);
        expq.push_back(exp_ctl(S_T0, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        ctl_t e;
        IR = mk_ir(5'b00101, 4'd1, 4'd4, 4'd6);
        fin_always = 0; alu_delay = 0;
        do_reset();
        expq.push_back(exp_ctl(S_T0, IR));
        expq.push_back(exp_ctl(S_T1, IR));
        expq.push_back(exp_ctl(S_T2, IR));
        expq.push_back(exp_ctl(S_T3, IR));
        expq.push_back(exp_ctl(S_T4, IR));
        for (int i = 0; i < TIMEOUT - 1; i++) expq.push_back(exp_ctl(S_T4W, IR));
        for (int i = 0; i < 4; i++) expq.push_back(exp_ctl(S_FLT, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL timeout cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
        clear = 1'b1;
        @(posedge Clock); #1;
        e = exp_ctl(S_RST, IR);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL timeout_clear: got %h expected %h", obs, e);
        end
        clear = 1'b0;
    endtask

    task automatic test_halt();
        ctl_t e;
        IR = mk_ir(5'b11011, 4'd3, 4'd3, 4'd3);
        fin_always = 1; alu_delay = 0;
        do_reset();
        expq.push_back(exp_ctl(S_T0, IR));
        expq.push_back(exp_ctl(S_T1, IR));
        expq.push_back(exp_ctl(S_T2, IR));
        for (int i = 0; i < 6; i++) expq.push_back(exp_ctl(S_HLT, IR));
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL halt cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
        // Second run: abort an instruction while it waits on the ALU.
        IR = 32'hC8918000;
        fin_always = 0; alu_delay = 0;
        do_reset();
        push_instr(IR, 2);
        void'(expq.pop_back());
        for (int cyc = 0; expq.size() > 0; cyc++) begin
            @(posedge Clock); #1;
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL abort_wait cycle %0d: got %h expected %h", cyc, obs, e);
            end
        end
        clear = 1'b1;
        @(posedge Clock); #1;
        e = exp_ctl(S_RST, IR);
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL abort_clear: got %h expected %h", obs, e);
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shr();
        test_same_cycle();
        test_mul();
        test_back_to_back();
        test_timeout();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
